// File: rtl/writeback_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | writeback_arbiter_if : issue, ALU, long-latency and write-port bundle    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface writeback_arbiter_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic [4:0]      issue_rd;
  logic            issue_long;
  logic            issue_stall;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lw_valid;
  logic [4:0]      lw_rd;
  logic [XLEN-1:0] lw_data;
  logic            lw_ready;
  logic            reg_write;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [31:0]     busy;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    output alu_valid, alu_rd, alu_data, lw_valid, lw_rd, lw_data,
    input  issue_stall, lw_ready, reg_write, rd, write_data, busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
    input  alu_valid, alu_rd, alu_data, lw_valid, lw_rd, lw_data,
    output issue_stall, lw_ready, reg_write, rd, write_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// +--------------------------------------------------------------------------+
// | writeback_arbiter : ALU/long-result write-port merge + pending scoreboard |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module writeback_arbiter #(
  parameter int XLEN    = 32,
  parameter int Q_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  writeback_arbiter_if.slave bus
);
  localparam int c_aw = $clog2(Q_DEPTH);

  logic [4:0]      r_mem_rd   [Q_DEPTH];
  logic [XLEN-1:0] r_mem_data [Q_DEPTH];
  logic [c_aw:0]   r_wptr;
  logic [c_aw:0]   r_rptr;
  logic [31:0]     r_busy;
  logic            r_reg_write;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic            r_src_long;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_stall;
  logic            w_issue_accept;
  logic [31:0]     w_busy_next;
  logic [c_aw-1:0] w_widx;
  logic [c_aw-1:0] w_ridx;

  assign w_widx  = r_wptr[c_aw-1:0];
  assign w_ridx  = r_rptr[c_aw-1:0];
  assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) && (w_widx == w_ridx);
  assign w_empty = (r_wptr == r_rptr);

  // Readiness depends on current occupancy only: a same-cycle pop never frees a slot early.
  assign w_push = bus.lw_valid && !w_full;
  assign w_pop  = !bus.alu_valid && !w_empty;

  assign w_stall        = bus.issue_valid &&
                          (r_busy[bus.issue_rs1] | r_busy[bus.issue_rs2] | r_busy[bus.issue_rd]);
  assign w_issue_accept = bus.issue_valid && !w_stall;

  // Clear first so that a same-register set takes priority; bit 0 never tracks.
  always_comb begin
    w_busy_next = r_busy;
    if (r_reg_write && r_src_long) begin
      w_busy_next[r_rd] = 1'b0;
    end
    if (w_issue_accept && bus.issue_long) begin
      w_busy_next[bus.issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[w_widx]   <= bus.lw_rd;
      r_mem_data[w_widx] <= bus.lw_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_busy      <= '0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wdata     <= '0;
      r_src_long  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{c_aw{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{c_aw{1'b0}}, 1'b1};
      end
      r_busy <= w_busy_next;
      if (bus.alu_valid) begin
        r_reg_write <= 1'b1;
        r_rd        <= bus.alu_rd;
        r_wdata     <= bus.alu_data;
        r_src_long  <= 1'b0;
      end else if (!w_empty) begin
        r_reg_write <= 1'b1;
        r_rd        <= r_mem_rd[w_ridx];
        r_wdata     <= r_mem_data[w_ridx];
        r_src_long  <= 1'b1;
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  assign bus.issue_stall = w_stall;
  assign bus.lw_ready    = !w_full;
  assign bus.reg_write   = r_reg_write;
  assign bus.rd          = r_rd;
  assign bus.write_data  = r_wdata;
  assign bus.busy        = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_writeback_arbiter : directed + randomized bench with queue model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_writeback_arbiter;
  localparam int XLEN    = 32;
  localparam int Q_DEPTH = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  writeback_arbiter_if #(.XLEN(XLEN)) bus ();

  writeback_arbiter #(.XLEN(XLEN), .Q_DEPTH(Q_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: FIFO as a queue, scoreboard as a bit vector, write port as a triple.
  ent_t            q[$];
  logic [31:0]     m_busy;
  logic            m_wr;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic            m_long;

  function automatic logic m_stall();
    logic [31:0] b;
    b    = m_busy;
    b[0] = 1'b0;
    return bus.issue_valid && (b[bus.issue_rs1] || b[bus.issue_rs2] || b[bus.issue_rd]);
  endfunction

  task automatic tick();
    logic        full;
    logic        stall;
    logic [31:0] nb;
    ent_t        e;
    full  = (q.size() == Q_DEPTH);
    stall = m_stall();
    if (!rst_n) begin
      q.delete();
      m_busy = '0; m_wr = 1'b0; m_rd = '0; m_data = '0; m_long = 1'b0;
    end else begin
      nb = m_busy;
      if (m_wr && m_long && m_rd != 5'd0) nb[m_rd] = 1'b0;
      if (bus.issue_valid && !stall && bus.issue_long && bus.issue_rd != 5'd0) nb[bus.issue_rd] = 1'b1;
      if (bus.alu_valid) begin
        m_wr = 1'b1; m_rd = bus.alu_rd; m_data = bus.alu_data; m_long = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_wr = 1'b1; m_rd = e.rd; m_data = e.data; m_long = 1'b1;
      end else begin
        m_wr = 1'b0;
      end
      if (bus.lw_valid && !full) begin
        e.rd = bus.lw_rd; e.data = bus.lw_data;
        q.push_back(e);
      end
      m_busy = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_rd = '0;
    bus.issue_long = 1'b0; bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lw_valid = 1'b0; bus.lw_rd = '0; bus.lw_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total++; if (bus.reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", bus.reg_write); else passed++;
    total++; if (bus.busy !== 32'h0) $display("FAIL reset_busy: got %h want 0", bus.busy); else passed++;
    total++; if (bus.rd !== 5'd0 || bus.write_data !== 32'h0) $display("FAIL reset_rd_data: got %0d/%h want 0/0", bus.rd, bus.write_data); else passed++;
    total++; if (bus.lw_ready !== 1'b1) $display("FAIL reset_lw_ready: got %b want 1", bus.lw_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rs1 = 5'($urandom); bus.issue_rs2 = 5'($urandom); bus.issue_rd = 5'($urandom);
      #1;
      total++; if (bus.issue_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.issue_stall); else passed++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_raw_long();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd5;
    #1;
    total++; if (bus.issue_stall !== 1'b0) $display("FAIL raw_first_issue: got %b want 0", bus.issue_stall); else passed++;
    tick();
    total++; if (bus.busy !== 32'h20) $display("FAIL raw_busy_set: got %h want 00000020", bus.busy); else passed++;
    bus.issue_long = 1'b0; bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd5;
    tick(); tick();
    total++; if (bus.issue_stall !== 1'b1) $display("FAIL raw_stall_held: got %b want 1", bus.issue_stall); else passed++;
    bus.lw_valid = 1'b1; bus.lw_rd = 5'd5; bus.lw_data = 32'hDEADBEEF;
    tick();
    bus.lw_valid = 1'b0;
    total++; if (bus.reg_write !== 1'b0 || bus.busy !== 32'h20) $display("FAIL raw_after_accept: got we=%b busy=%h want 0/00000020", bus.reg_write, bus.busy); else passed++;
    tick();
    total++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd5 || bus.write_data !== 32'hDEADBEEF)
      $display("FAIL raw_write: got %b/%0d/%h want 1/5/deadbeef", bus.reg_write, bus.rd, bus.write_data); else passed++;
    total++; if (bus.issue_stall !== 1'b1) $display("FAIL raw_stall_at_write: got %b want 1", bus.issue_stall); else passed++;
    tick();
    total++; if (bus.busy !== 32'h0 || bus.issue_stall !== 1'b0) $display("FAIL raw_clear: got busy=%h stall=%b want 0/0", bus.busy, bus.issue_stall); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(k + 1); bus.alu_data = 32'hA000 + 32'(k);
      bus.lw_valid = (k < 4); bus.lw_rd = 5'(10 + k); bus.lw_data = 32'hB000 + 32'(k);
      #1;
      total++; if (bus.lw_ready !== (k < 4)) $display("FAIL b2b_lw_ready%0d: got %b want %b", k, bus.lw_ready, (k < 4)); else passed++;
      tick();
      total++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'(k + 1) || bus.write_data !== 32'hA000 + 32'(k))
        $display("FAIL b2b_alu%0d: got %b/%0d/%h want 1/%0d/%h", k, bus.reg_write, bus.rd, bus.write_data, k + 1, 32'hA000 + 32'(k)); else passed++;
    end
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      #1;
      total++; if (bus.lw_ready !== (j != 0)) $display("FAIL b2b_drain_ready%0d: got %b want %b", j, bus.lw_ready, (j != 0)); else passed++;
      tick();
      total++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'(10 + j) || bus.write_data !== 32'hB000 + 32'(j))
        $display("FAIL b2b_long%0d: got %b/%0d/%h want 1/%0d/%h", j, bus.reg_write, bus.rd, bus.write_data, 10 + j, 32'hB000 + 32'(j)); else passed++;
    end
    tick();
    total++; if (bus.reg_write !== 1'b0) $display("FAIL b2b_idle: got %b want 0", bus.reg_write); else passed++;
  endtask

  task automatic test_full_pop_wrap();
    logic [XLEN-1:0] saved[3*Q_DEPTH];
    for (int i = 0; i < Q_DEPTH; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
      bus.lw_valid = 1'b1; bus.lw_rd = 5'(20 + i); bus.lw_data = 32'hC000 + 32'(i);
      tick();
    end
    bus.alu_valid = 1'b0; bus.lw_rd = 5'd30; bus.lw_data = 32'hC0C0;
    #1;
    total++; if (bus.lw_ready !== 1'b0) $display("FAIL full_ready_low: got %b want 0", bus.lw_ready); else passed++;
    tick();
    total++; if (bus.rd !== 5'd20 || bus.reg_write !== 1'b1) $display("FAIL full_pop: got %b/%0d want 1/20", bus.reg_write, bus.rd); else passed++;
    total++; if (bus.lw_ready !== 1'b1) $display("FAIL full_no_push: got %b want 1", bus.lw_ready); else passed++;
    tick();
    bus.lw_valid = 1'b0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      tick();
      total++; if (bus.reg_write !== m_wr || bus.rd !== m_rd || bus.write_data !== m_data)
        $display("FAIL full_drain%0d: got %b/%0d/%h want %b/%0d/%h", i, bus.reg_write, bus.rd, bus.write_data, m_wr, m_rd, m_data); else passed++;
    end
    tick();
    for (int i = 0; i <= 3 * Q_DEPTH; i++) begin
      if (i < 3 * Q_DEPTH) begin
        saved[i] = $urandom;
        bus.lw_valid = 1'b1; bus.lw_rd = 5'(i); bus.lw_data = saved[i];
      end else begin
        bus.lw_valid = 1'b0;
      end
      tick();
      if (i > 0) begin
        total++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'(i - 1) || bus.write_data !== saved[i - 1])
          $display("FAIL wrap%0d: got %b/%0d/%h want 1/%0d/%h", i, bus.reg_write, bus.rd, bus.write_data, i - 1, saved[i - 1]); else passed++;
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_rd_zero();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd0;
    tick();
    bus.issue_long = 1'b0; bus.issue_rs1 = 5'd0;
    #1;
    total++; if (bus.issue_stall !== 1'b0 || bus.busy !== 32'h0) $display("FAIL zero_issue: got stall=%b busy=%h want 0/0", bus.issue_stall, bus.busy); else passed++;
    idle_inputs();
    bus.lw_valid = 1'b1; bus.lw_rd = 5'd0; bus.lw_data = 32'h1234;
    tick();
    bus.lw_valid = 1'b0;
    tick();
    total++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd0 || bus.write_data !== 32'h1234)
      $display("FAIL zero_write: got %b/%0d/%h want 1/0/1234", bus.reg_write, bus.rd, bus.write_data); else passed++;
    tick();
    total++; if (bus.reg_write !== 1'b0) $display("FAIL zero_single_pulse: got %b want 0", bus.reg_write); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd3;
    tick();
    bus.issue_rd = 5'd7;
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
      bus.lw_valid = 1'b1; bus.lw_rd = 5'(3 + 4 * i); bus.lw_data = 32'h5A5A + 32'(i);
      tick();
    end
    idle_inputs();
    total++; if (bus.busy !== 32'h88) $display("FAIL mid_busy_before: got %h want 00000088", bus.busy); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (bus.reg_write !== 1'b0 || bus.rd !== 5'd0 || bus.write_data !== 32'h0 || bus.busy !== 32'h0 || bus.lw_ready !== 1'b1)
      $display("FAIL mid_reset_vals: got %b/%0d/%h/%h/%b want 0/0/0/0/1", bus.reg_write, bus.rd, bus.write_data, bus.busy, bus.lw_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.reg_write !== 1'b0) $display("FAIL mid_no_write%0d: got %b want 0", i, bus.reg_write); else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_rs1 = 5'($urandom_range(0, 7)); bus.issue_rs2 = 5'($urandom_range(0, 7));
      bus.issue_rd = 5'($urandom_range(0, 7)); bus.issue_long = ($urandom_range(0, 1) == 1);
      bus.alu_valid = ($urandom_range(0, 2) == 0);
      bus.alu_rd = 5'($urandom); bus.alu_data = $urandom;
      bus.lw_valid = ($urandom_range(0, 1) == 1);
      bus.lw_rd = 5'($urandom_range(0, 7)); bus.lw_data = $urandom;
      #1;
      total++; if (bus.lw_ready !== (q.size() < Q_DEPTH) || bus.issue_stall !== m_stall())
        $display("FAIL rand_comb%0d: got ready=%b stall=%b want %b/%b", c, bus.lw_ready, bus.issue_stall, (q.size() < Q_DEPTH), m_stall()); else passed++;
      tick();
      total++; if (bus.reg_write !== m_wr || bus.rd !== m_rd || bus.write_data !== m_data || bus.busy !== m_busy)
        $display("FAIL rand_seq%0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", c, bus.reg_write, bus.rd, bus.write_data, bus.busy, m_wr, m_rd, m_data, m_busy); else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    m_busy = '0; m_wr = 1'b0; m_rd = '0; m_data = '0; m_long = 1'b0;
    idle_inputs();
    test_reset();
    test_raw_long();
    test_back_to_back();
    test_full_pop_wrap();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
